// File: rtl/part_select_pkg.sv
// Shared types and helpers for the part-select arbiter: FSM state encoding and
// the legality rule for a [left:right] slice request.
package part_select_pkg;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXTRACT,
        PS_RESP
    } ps_state_e;

    function automatic logic range_ok(input int left, input int right,
                                      input int data_w, input int out_w);
        return (left >= right) && (left < data_w) && ((left - right + 1) <= out_w);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward
// from ptr+1 (mod NUM_REQ). The pointer itself lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    always_comb begin
        int idx;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        idx          = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_idx         = ID_W'(idx);
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/part_select_arbiter.sv
// Shared registered part-select unit: round-robin grants one requester at a time,
// returns word[left:right] zero-extended to OUT_W, tagged with the requester id.
module part_select_arbiter
    import part_select_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int OUT_W   = 16,
    localparam int IDX_W  = $clog2(DATA_W),
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*IDX_W-1:0]   req_left,
    input  logic [NUM_REQ*IDX_W-1:0]   req_right,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [ID_W-1:0]            out_id,
    output logic                       out_err
);

    ps_state_e state, state_nxt;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               gnt_any;
    logic               accept;
    logic               done;

    logic [DATA_W-1:0]  word_q;
    logic [IDX_W-1:0]   left_q;
    logic [IDX_W-1:0]   right_q;
    logic [ID_W-1:0]    id_q;

    logic               legal;
    logic [IDX_W:0]     width;
    logic [DATA_W:0]    mask;
    logic [DATA_W:0]    sliced;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req          (req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (gnt_onehot),
        .grant_idx    (gnt_idx),
        .any          (gnt_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PS_IDLE;
        else     state <= state_nxt;
    end

    // req_ready is gated by rst so it reads 0 while reset is held
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        out_valid = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            PS_IDLE: begin
                if (gnt_any && !rst) begin
                    req_ready = gnt_onehot;
                    accept    = 1'b1;
                    state_nxt = PS_EXTRACT;
                end
            end
            PS_EXTRACT: state_nxt = PS_RESP;
            PS_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done      = 1'b1;
                    state_nxt = PS_IDLE;
                end
            end
            default: state_nxt = PS_IDLE;
        endcase
    end

    // One spare bit on the mask keeps a full DATA_W-wide slice from overflowing
    assign legal  = range_ok(int'(left_q), int'(right_q), DATA_W, OUT_W);
    assign width  = {1'b0, left_q} - {1'b0, right_q} + (IDX_W+1)'(1);
    assign mask   = ((DATA_W+1)'(1) << width) - (DATA_W+1)'(1);
    assign sliced = {1'b0, word_q >> right_q} & mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            id_q     <= '0;
            out_data <= '0;
            out_id   <= '0;
            out_err  <= 1'b0;
            rr_ptr   <= ID_W'(NUM_REQ-1);
        end else begin
            if (accept) begin
                word_q  <= req_data[gnt_idx*DATA_W +: DATA_W];
                left_q  <= req_left[gnt_idx*IDX_W +: IDX_W];
                right_q <= req_right[gnt_idx*IDX_W +: IDX_W];
                id_q    <= gnt_idx;
            end
            if (state == PS_EXTRACT) begin
                out_data <= legal ? OUT_W'(sliced) : '0;
                out_err  <= !legal;
                out_id   <= id_q;
            end
            if (done) rr_ptr <= out_id;
        end
    end

endmodule
